// File: rtl/data_path.sv
// Register-file datapath: NUM_REGS x WIDTH registers, a dedicated R1 port, addressed ports and a 4-function ALU.
// Optional macro DATAPATH_BYPASS_EN forwards same-cycle write data onto the read ports.
module data_path #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 8,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             write_enable1,
    input  logic [WIDTH-1:0] write_data1,
    output logic [WIDTH-1:0] read_data1,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero
);

    logic [WIDTH-1:0] regs_r [NUM_REGS];
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;
    logic [WIDTH-1:0] r1_s;
    logic [WIDTH-1:0] alu_s;

    // Non-power-of-two register counts leave addresses that map to nothing.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (32'(addr) < 32'(NUM_REGS));
    endfunction

    // Stored value at addr, with optional forwarding of this cycle's write.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             we1,
        input logic [WIDTH-1:0] wd1,
        input logic             we,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        logic [WIDTH-1:0] val;
        if (!addr_ok(addr)) begin
            val = {WIDTH{1'b0}};
        end else begin
            val = stored;
`ifdef DATAPATH_BYPASS_EN
            if (we1 && (addr == AW'(1))) begin
                val = wd1;
            end else if (we && addr_ok(wa) && (wa == addr)) begin
                val = wd;
            end else begin
                val = stored;
            end
`endif
        end
        return val;
    endfunction

    // Register file update; the dedicated R1 port beats the general port on a collision.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (write_enable1 && (i == 1)) begin
                    regs_r[i] <= write_data1;
                end else if (wr_en && addr_ok(wr_addr) && (32'(wr_addr) == 32'(i))) begin
                    regs_r[i] <= wr_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Read ports, including the always-visible R1 path.
    always_comb begin
        rd_a_s = {WIDTH{1'b0}};
        rd_b_s = {WIDTH{1'b0}};
        r1_s   = {WIDTH{1'b0}};
        if (addr_ok(rd_addr_a)) begin
            rd_a_s = read_port(rd_addr_a, regs_r[rd_addr_a], write_enable1, write_data1,
                               wr_en, wr_addr, wr_data);
        end else begin
            rd_a_s = {WIDTH{1'b0}};
        end
        if (addr_ok(rd_addr_b)) begin
            rd_b_s = read_port(rd_addr_b, regs_r[rd_addr_b], write_enable1, write_data1,
                               wr_en, wr_addr, wr_data);
        end else begin
            rd_b_s = {WIDTH{1'b0}};
        end
        r1_s = read_port(AW'(1), regs_r[1], write_enable1, write_data1,
                         wr_en, wr_addr, wr_data);
    end

    // ALU on the two read ports; sums and differences wrap modulo 2^WIDTH.
    always_comb begin
        alu_s = {WIDTH{1'b0}};
        case (alu_op)
            2'b00:   alu_s = rd_a_s + rd_b_s;
            2'b01:   alu_s = rd_a_s - rd_b_s;
            2'b10:   alu_s = rd_a_s & rd_b_s;
            2'b11:   alu_s = rd_a_s | rd_b_s;
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

    assign read_data1 = r1_s;
    assign rd_data_a  = rd_a_s;
    assign rd_data_b  = rd_b_s;
    assign alu_result = alu_s;
    assign alu_zero   = (alu_s == {WIDTH{1'b0}});

endmodule

// File: tb/tb_data_path.sv
// Directed-vector bench for data_path with hand-computed expectations.
module tb_data_path;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    logic             clock;
    logic             clear;
    logic             write_enable1;
    logic [WIDTH-1:0] write_data1;
    logic [WIDTH-1:0] read_data1;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    int n_vec;
    int n_err;

    data_path #(.WIDTH(WIDTH), .NUM_REGS(8)) dut (
        .clock         (clock),
        .clear         (clear),
        .write_enable1 (write_enable1),
        .write_data1   (write_data1),
        .read_data1    (read_data1),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr_a     (rd_addr_a),
        .rd_data_a     (rd_data_a),
        .rd_addr_b     (rd_addr_b),
        .rd_data_b     (rd_data_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear         = 1'b0;
        write_enable1 = 1'b1;
        write_data1   = 8'd171;
        wr_en         = 1'b1;
        wr_addr       = 3'd1;
        wr_data       = 8'd90;
        rd_addr_a     = 3'd1;
        rd_addr_b     = 3'd5;
        alu_op        = 2'b11;

        // Reset held across edges with enables active.
        #3;
        check_val("rst_r1", 32'(read_data1), 32'd0);
        check_val("rst_rda", 32'(rd_data_a), 32'd0);
        check_val("rst_rdb", 32'(rd_data_b), 32'd0);
        check_val("rst_zero", 32'(alu_zero), 32'd1);
        tick();
        tick();
        check_val("rst_hold_r1", 32'(read_data1), 32'd0);

        // Release, no enables for 3 edges.
        write_enable1 = 1'b0;
        wr_en         = 1'b0;
        clear         = 1'b1;
        repeat (3) tick();
        check_val("idle_r1", 32'(read_data1), 32'd0);
        check_val("idle_alu", 32'(alu_result), 32'd0);
        check_val("idle_zero", 32'(alu_zero), 32'd1);

        // Dedicated R1 write.
        write_enable1 = 1'b1;
        write_data1   = 8'd123;
        tick();
        write_enable1 = 1'b0;
        check_val("r1_write", 32'(read_data1), 32'd123);
        repeat (5) tick();
        check_val("r1_hold", 32'(read_data1), 32'd123);

        // Collision on R1: dedicated port wins, then general port alone.
        write_enable1 = 1'b1;
        write_data1   = 8'd123;
        wr_en         = 1'b1;
        wr_addr       = 3'd1;
        wr_data       = 8'd55;
        tick();
        check_val("collide_r1", 32'(read_data1), 32'd123);
        write_enable1 = 1'b0;
        tick();
        check_val("gen_r1", 32'(read_data1), 32'd55);
        check_val("gen_rda", 32'(rd_data_a), 32'd55);

        // ALU operands.
        wr_addr = 3'd2;
        wr_data = 8'd200;
        tick();
        wr_addr = 3'd3;
        wr_data = 8'd100;
        tick();
        wr_en     = 1'b0;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd3;
        alu_op    = 2'b00;
        #1;
        check_val("alu_add", 32'(alu_result), 32'd44);
        check_val("alu_add_z", 32'(alu_zero), 32'd0);
        alu_op = 2'b01;
        #1;
        check_val("alu_sub", 32'(alu_result), 32'd100);
        alu_op = 2'b10;
        #1;
        check_val("alu_and", 32'(alu_result), 32'd64);
        alu_op = 2'b11;
        #1;
        check_val("alu_or", 32'(alu_result), 32'd236);
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd2;
        alu_op    = 2'b01;
        #1;
        check_val("alu_sub_wrap", 32'(alu_result), 32'd156);
        rd_addr_b = 3'd3;
        #1;
        check_val("alu_sub_self", 32'(alu_result), 32'd0);
        check_val("alu_sub_self_z", 32'(alu_zero), 32'd1);

        // Asynchronous reset between edges.
        write_enable1 = 1'b1;
        write_data1   = 8'd123;
        tick();
        write_enable1 = 1'b0;
        check_val("pre_rst_r1", 32'(read_data1), 32'd123);
        rd_addr_a = 3'd2;
        #1;
        clear = 1'b0;
        #1;
        check_val("async_r1", 32'(read_data1), 32'd0);
        check_val("async_rda", 32'(rd_data_a), 32'd0);
        write_enable1 = 1'b1;
        write_data1   = 8'd99;
        tick();
        tick();
        check_val("rst_we_r1", 32'(read_data1), 32'd0);
        clear = 1'b1;
        #1;
        check_val("release_r1", 32'(read_data1), 32'd0);
        tick();
        write_enable1 = 1'b0;
        check_val("post_rel_r1", 32'(read_data1), 32'd99);

        // Same-cycle read of a register being written.
        wr_en     = 1'b1;
        wr_addr   = 3'd4;
        wr_data   = 8'd77;
        rd_addr_a = 3'd4;
        #1;
`ifdef DATAPATH_BYPASS_EN
        check_val("bypass_rda", 32'(rd_data_a), 32'd77);
`else
        check_val("nobypass_rda", 32'(rd_data_a), 32'd0);
`endif
        tick();
        wr_en = 1'b0;
        check_val("after_wr_rda", 32'(rd_data_a), 32'd77);

        // R0 is an ordinary register on the general port.
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 8'd255;
        tick();
        wr_en     = 1'b0;
        rd_addr_b = 3'd0;
        alu_op    = 2'b00;
        #1;
        check_val("r0_rdb", 32'(rd_data_b), 32'd255);
        check_val("alu_add_wrap", 32'(alu_result), 32'd76);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1);
    end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Small register-file datapath: NUM_REGS registers of WIDTH bits, each with asynchronous clear.
- One dedicated write port and one always-visible read port for register R1 (the tutorial "R1" path).
- One general addressed write port, two addressed read ports, and a combinational 4-function ALU fed by the two read ports.
- Sits between the control unit (drives enables, addresses and ALU opcode) and the system bus (supplies write data).

Parameters:
- WIDTH, 8, data width of every register, port and ALU operand.
- NUM_REGS, 8, number of registers R0..R(NUM_REGS-1). Minimum 2. Address width AW = $clog2(NUM_REGS).

Ports:
- clock  in  1  rising-edge clock for all registers.
- clear  in  1  asynchronous active-low reset; 0 clears all registers immediately.
- write_enable1  in  1  load write_data1 into R1 at the next rising edge.
- write_data1  in  WIDTH  data for R1 dedicated port.
- read_data1  out  WIDTH  current contents of R1, continuously.
- wr_en  in  1  general write enable.
- wr_addr  in  AW  general write target register.
- wr_data  in  WIDTH  general write data.
- rd_addr_a  in  AW  read port A address.
- rd_data_a  out  WIDTH  contents of register rd_addr_a.
- rd_addr_b  in  AW  read port B address.
- rd_data_b  out  WIDTH  contents of register rd_addr_b.
- alu_op  in  2  ALU function select.
- alu_result  out  WIDTH  ALU output.
- alu_zero  out  1  1 when alu_result == 0.

Behaviour:
- Reset: clear=0 asynchronously forces every register to 0, independent of clock. Hence read_data1, rd_data_a/b and alu_result read 0, and alu_zero reads 1 (given alu_op 00/01/10/11 on zero operands). Registers hold 0 while clear=0; writes are ignored during reset.
- Writes: sampled on the rising edge of clock when clear=1.
  - write_enable1=1: R1 <= write_data1.
  - wr_en=1: R[wr_addr] <= wr_data.
  - Both enables targeting R1 in the same edge: write_enable1 wins.
  - wr_addr >= NUM_REGS: write ignored.
- Registers without an active write hold their value.
- Reads: combinational from register state; one-cycle write-to-read latency, with no same-cycle forwarding unless the optional feature is enabled. Read address >= NUM_REGS returns 0.
- read_data1 always equals R1, regardless of the rd_addr ports.
- ALU: combinational, A = rd_data_a, B = rd_data_b.
  - 00: A+B, modulo 2^WIDTH, carry dropped.
  - 01: A-B, modulo 2^WIDTH (two's complement wrap).
  - 10: A&B.
  - 11: A|B.
- No flags beyond alu_zero.
- Reset asserted mid-operation: outputs go to reset values within the same delta, and no pending write completes. On release (clear 0->1), the first write occurs at the next rising edge.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro DATAPATH_BYPASS_EN.
- Defined: each read port forwards the write data being presented this cycle when the address matches an active write. Priority: write_enable1 (for address 1) over wr_en. read_data1 likewise shows write_data1 while write_enable1=1. The ALU sees the forwarded values. Register update timing is unchanged.
- Not defined: reads always return stored register contents (default behaviour above).

Test Plan:
- Reset: clear=0 with random inputs -> read_data1=0, rd_data_a/b=0, alu_zero=1. Release clear, no enables for 3 edges -> all outputs still 0.
- R1 write: clear=1, write_enable1=1, write_data1=123 for one edge, then write_enable1=0 -> read_data1=123 after the edge, and it stays 123 for 5 further edges.
- Collision: wr_en=1, wr_addr=1, wr_data=55 and write_enable1=1, write_data1=123 on the same edge -> read_data1=123. Then wr_en alone with 55 -> read_data1=55.
- ALU: write R2=200, R3=100, rd_addr_a=2, rd_addr_b=3.
  - op00 -> 44.
  - op01 -> 100.
  - op10 -> 64.
  - op11 -> 236.
  - Swap addresses with op01 -> 156.
  - Both addresses 3 with op01 -> 0 and alu_zero=1.
- Async reset mid-operation: R1=123, drop clear between clock edges -> read_data1=0 before the next edge. Assert write_enable1 during reset -> R1 stays 0.
- Bypass (only with DATAPATH_BYPASS_EN): wr_en=1, wr_addr=4, wr_data=77, rd_addr_a=4 -> rd_data_a=77 before the edge. Without the macro -> old value 0 until after the edge.
